// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF race evaluator.
//   apuf_state_e : evaluator FSM states
//   apuf_clog2   : ceil(log2(v)), minimum 1, usable in constant expressions
//   PHASE_W      : width of the launch/relax phase timer
package apuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RACE  = 2'd1,
    RELAX = 2'd2,
    DONE  = 2'd3
  } apuf_state_e;

  localparam int PHASE_W = 16;

  function automatic int apuf_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apuf_race_evaluator_if.sv
// Challenge/response handshake bundle between the CRP controller (master)
// and the race evaluator (slave).
//   chal_in/chal_valid/chal_ready : challenge offer
//   resp_out/resp_ones/resp_valid/resp_ready : majority response return
interface apuf_race_evaluator_if #(
  parameter int CHAL_W = 64,
  parameter int NEVAL  = 15
);
  import apuf_pkg::*;

  localparam int CNT_W = apuf_clog2(NEVAL + 1);

  logic [CHAL_W-1:0] chal_in;
  logic              chal_valid;
  logic              chal_ready;
  logic              resp_out;
  logic [CNT_W-1:0]  resp_ones;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output chal_in, chal_valid, resp_ready,
    input  chal_ready, resp_out, resp_ones, resp_valid
  );

  modport slave (
    input  chal_in, chal_valid, resp_ready,
    output chal_ready, resp_out, resp_ones, resp_valid
  );

endinterface

// File: rtl/apuf_sync2.sv
// Two-flop synchroniser for asynchronous PUF taps (arbiter latch outputs).
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input bits
//   q   : synchronised output bits, two clk edges of latency
module apuf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // One independent two-stage chain per bit; bits are not coherent with
  // each other, which is fine for independent latch taps.
  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge clk) begin
      if (rst) begin
        meta_q[gi] <= 1'b0;
        sync_q[gi] <= 1'b0;
      end else begin
        meta_q[gi] <= d[gi];
        sync_q[gi] <= meta_q[gi];
      end
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/apuf_race_evaluator.sv
// Arbiter-PUF race evaluator.  Holds an accepted challenge on the switch
// chain, launches NEVAL rising-edge races (SETTLE_CYC cycles high, then
// SETTLE_CYC cycles low), samples the synchronised arbiter output at the end
// of each high phase and returns the majority bit plus the ones count.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : challenge in / response out handshakes (slave side)
//   chal_out   : registered switch control bits
//   launch     : registered race stimulus into both chain inputs
//   arb_in     : raw asynchronous arbiter latch output
//   busy       : high whenever not idle
module apuf_race_evaluator
  import apuf_pkg::*;
#(
  parameter int CHAL_W     = 64,
  parameter int NEVAL      = 15,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  apuf_race_evaluator_if.slave bus,
  output logic [CHAL_W-1:0] chal_out,
  output logic              launch,
  input  logic              arb_in,
  output logic              busy
);

  localparam int CNT_W = apuf_clog2(NEVAL + 1);

  if (NEVAL < 1 || (NEVAL % 2) == 0) begin : g_bad_neval
    $error("apuf_race_evaluator: NEVAL must be odd and >= 1");
  end
  if (SETTLE_CYC < 4 || SETTLE_CYC > (1 << PHASE_W)) begin : g_bad_settle
    $error("apuf_race_evaluator: SETTLE_CYC out of range");
  end

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   EVAL_LAST  = CNT_W'(NEVAL - 1);
  localparam logic [CNT_W-1:0]   HALF       = CNT_W'(NEVAL / 2);

  apuf_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   eval_q, eval_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic [CHAL_W-1:0]  chal_q, chal_d;
  logic               launch_q, launch_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_out_q, resp_out_d;
  logic [CNT_W-1:0]   resp_ones_q, resp_ones_d;
  logic               arb_s;

  apuf_sync2 #(.W(1)) u_arb_sync (
    .clk (clk),
    .rst (rst),
    .d   (arb_in),
    .q   (arb_s)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    chal_d       = chal_q;
    launch_d     = launch_q;
    resp_valid_d = resp_valid_q;
    resp_out_d   = resp_out_q;
    resp_ones_d  = resp_ones_q;

    case (state_q)
      IDLE: begin
        if (bus.chal_valid) begin
          chal_d   = bus.chal_in;
          eval_d   = '0;
          ones_d   = '0;
          phase_d  = '0;
          launch_d = 1'b1;
          state_d  = RACE;
        end
      end
      RACE: begin
        if (phase_q == PHASE_LAST) begin
          // Race window closes: the arbiter has had SETTLE_CYC cycles to
          // resolve, and arb_s already carries two cycles of sync latency.
          phase_d  = '0;
          ones_d   = ones_q + CNT_W'(arb_s);
          launch_d = 1'b0;
          state_d  = RELAX;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RELAX: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          eval_d  = eval_q + 1'b1;
          if (eval_q == EVAL_LAST) begin
            state_d = DONE;
          end else begin
            launch_d = 1'b1;
            state_d  = RACE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        // First DONE cycle captures the result; valid rises one edge after
        // entering DONE and then holds until the consumer takes it.
        if (!resp_valid_q) begin
          resp_valid_d = 1'b1;
          resp_ones_d  = ones_q;
          resp_out_d   = (ones_q > HALF);
        end else if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      chal_q       <= '0;
      launch_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_out_q   <= 1'b0;
      resp_ones_q  <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      chal_q       <= chal_d;
      launch_q     <= launch_d;
      resp_valid_q <= resp_valid_d;
      resp_out_q   <= resp_out_d;
      resp_ones_q  <= resp_ones_d;
    end
  end

  assign chal_out       = chal_q;
  assign launch         = launch_q;
  assign busy           = (state_q != IDLE);
  assign bus.chal_ready = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_ones  = resp_ones_q;

endmodule

// File: tb/tb_apuf_race_evaluator.sv
module tb_apuf_race_evaluator;

  localparam int CW   = 64;
  localparam int N    = 5;
  localparam int S    = 4;
  localparam int LAST = 2 * S * N + 1;

  logic          clk;
  logic          rst;
  logic [CW-1:0] chal_out;
  logic          launch;
  logic          arb_in;
  logic          busy;

  int n_vec;
  int n_err;

  apuf_race_evaluator_if #(.CHAL_W(CW), .NEVAL(N)) bus ();

  apuf_race_evaluator #(.CHAL_W(CW), .NEVAL(N), .SETTLE_CYC(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .chal_out (chal_out),
    .launch   (launch),
    .arb_in   (arb_in),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one full evaluation and check it cycle by cycle against the timing
  // rules: launch high S / low S repeated N times from the accepting edge,
  // valid exactly LAST cycles after acceptance, majority over per-race bits.
  task automatic run_eval(input logic [CW-1:0] chal, input logic [N-1:0] bits,
                          input bit glitch, input int hold, input bit early_ready,
                          input bit next_valid, input logic [CW-1:0] next_chal,
                          input bit pre, input int abort_k);
    int   ones_exp;
    logic out_exp;
    logic exp_launch;
    logic exp_rv;
    ones_exp = $countones(bits);
    out_exp  = (ones_exp > N / 2);
    arb_in     = bits[0];
    bus.resp_ready = early_ready;
    if (!pre) begin
      bus.chal_in    = chal;
      bus.chal_valid = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    for (int k = 0; k <= LAST; k++) begin
      exp_launch = (k < 2 * S * N) && ((k % (2 * S)) < S);
      exp_rv     = (k == LAST);
      n_vec++;
      if (launch !== exp_launch) begin
        n_err++; $display("FAIL launch k=%0d got %b exp %b", k, launch, exp_launch);
      end
      n_vec++;
      if (bus.resp_valid !== exp_rv) begin
        n_err++; $display("FAIL resp_valid k=%0d got %b exp %b", k, bus.resp_valid, exp_rv);
      end
      n_vec++;
      if (chal_out !== chal) begin
        n_err++; $display("FAIL chal_out_stable k=%0d got %h exp %h", k, chal_out, chal);
      end
      n_vec++;
      if (busy !== 1'b1 || bus.chal_ready !== 1'b0) begin
        n_err++; $display("FAIL busy_ready k=%0d got busy=%b rdy=%b exp busy=1 rdy=0", k, busy, bus.chal_ready);
      end
      if (k == abort_k) begin
        bus.chal_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (launch !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.chal_ready !== 1'b1 ||
            chal_out !== '0 || bus.resp_ones !== '0 || bus.resp_out !== 1'b0) begin
          n_err++;
          $display("FAIL mid_reset got launch=%b busy=%b rv=%b rdy=%b chal=%h ones=%0d out=%b exp 0 0 0 1 0 0 0",
                   launch, busy, bus.resp_valid, bus.chal_ready, chal_out, bus.resp_ones, bus.resp_out);
        end
        $display("eval chal=%h aborted by reset at k=%0d", chal, k);
        return;
      end
      bus.chal_in    = {$urandom, $urandom};
      bus.chal_valid = 1'($urandom_range(0, 1));
      if ((k % (2 * S)) == S && (k / (2 * S)) + 1 < N) arb_in = bits[(k / (2 * S)) + 1];
      if (glitch && k < 2 * S * N && (k % (2 * S)) == S - 2) arb_in = ~bits[k / (2 * S)];
      if (k < LAST) begin
        @(posedge clk); @(negedge clk);
      end
    end
    n_vec++;
    if (bus.resp_out !== out_exp || bus.resp_ones !== 3'(ones_exp)) begin
      n_err++;
      $display("FAIL response got out=%b ones=%0d exp out=%b ones=%0d", bus.resp_out, bus.resp_ones, out_exp, ones_exp);
    end
    for (int h = 0; h < hold; h++) begin
      bus.chal_valid = next_valid ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (bus.resp_valid !== 1'b1 || bus.resp_out !== out_exp || bus.resp_ones !== 3'(ones_exp) ||
          chal_out !== chal || bus.chal_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure h=%0d got rv=%b out=%b ones=%0d chal=%h rdy=%b exp 1 %b %0d %h 0",
                 h, bus.resp_valid, bus.resp_out, bus.resp_ones, chal_out, bus.chal_ready, out_exp, ones_exp, chal);
      end
    end
    bus.resp_ready = 1'b1;
    bus.chal_valid = next_valid;
    bus.chal_in    = next_chal;
    @(posedge clk); @(negedge clk);
    bus.resp_ready = 1'b0;
    n_vec++;
    if (bus.resp_valid !== 1'b0 || bus.chal_ready !== 1'b1 || busy !== 1'b0 || chal_out !== chal) begin
      n_err++;
      $display("FAIL handshake got rv=%b rdy=%b busy=%b chal=%h exp 0 1 0 %h",
               bus.resp_valid, bus.chal_ready, busy, chal_out, chal);
    end
    $display("eval chal=%h bits=%b glitch=%0d -> out=%b ones=%0d", chal, bits, glitch, out_exp, ones_exp);
  endtask

  task automatic test_reset();
    rst = 1'b1; arb_in = 1'b0;
    bus.chal_valid = 1'b0; bus.chal_in = '0; bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (launch !== 1'b0 || busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.chal_ready !== 1'b1 ||
        chal_out !== '0 || bus.resp_ones !== '0 || bus.resp_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset got launch=%b busy=%b rv=%b rdy=%b chal=%h ones=%0d out=%b exp 0 0 0 1 0 0 0",
               launch, busy, bus.resp_valid, bus.chal_ready, chal_out, bus.resp_ones, bus.resp_out);
    end
    $display("reset checked");
  endtask

  task automatic test_timing();
    run_eval(64'hA5A5_A5A5_A5A5_A5A5, 5'b11111, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic test_majority();
    // bit r is race r+1
    run_eval({$urandom, $urandom}, 5'b01101, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0, -1);
    run_eval({$urandom, $urandom}, 5'b10010, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic test_back_pressure();
    logic [CW-1:0] nxt;
    nxt = {$urandom, $urandom};
    run_eval({$urandom, $urandom}, 5'($urandom), 1'b0, 10, 1'b0, 1'b1, nxt, 1'b0, -1);
    run_eval(nxt, 5'($urandom), 1'b0, 0, 1'b0, 1'b0, '0, 1'b1, -1);
  endtask

  task automatic test_early_ready();
    run_eval({$urandom, $urandom}, 5'($urandom), 1'b0, 0, 1'b1, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    run_eval({$urandom, $urandom}, 5'b11111, 1'b0, 0, 1'b0, 1'b0, '0, 1'b0, 4 * S + 1);
    run_eval({$urandom, $urandom}, 5'($urandom), 1'b0, 0, 1'b0, 1'b0, '0, 1'b0, -1);
  endtask

  task automatic test_sync();
    for (int i = 0; i < 3; i++) begin
      run_eval({$urandom, $urandom}, 5'($urandom), 1'b1, 0, 1'b0, 1'b0, '0, 1'b0, -1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      run_eval({$urandom, $urandom}, 5'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'b0, 1'b0, '0, 1'b0, -1);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_timing();
    test_majority();
    test_back_pressure();
    test_early_ready();
    test_reset_mid();
    test_sync();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Every DUT wait above is a fixed cycle count, so this only guards
  // against a simulator-level stall.
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apuf_race_evaluator.md
Name: apuf_race_evaluator

Overview:
- Drives and resolves one arbiter-PUF delay line built from chained 2-to-2 switch stages.
- Accepts a challenge over a valid/ready handshake and holds it on the switch control lines. Repeatedly launches a rising edge into the chain and samples the arbiter latch output once per race.
- Majority-votes NEVAL races into a 1-bit response plus a ones-count (reliability metric), returned over valid/ready.
- Sits between the challenge/response controller and the switch chain/arbiter latch.

Parameters:
- CHAL_W, 64, challenge width; one control bit per switch stage.
- NEVAL, 15, races per challenge; must be odd and at least 1.
- SETTLE_CYC, 8, clk cycles per launch phase (high) and per relax phase (low); must be at least 4.
- CNT_W, clog2(NEVAL+1), ones-counter width; derived, not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- chal_in  in  CHAL_W  challenge.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  high only in IDLE.
- chal_out  out  CHAL_W  registered switch control bits to chain stages.
- launch  out  1  registered race stimulus into both chain inputs.
- arb_in  in  1  raw (asynchronous) arbiter latch output.
- resp_out  out  1  majority response.
- resp_ones  out  CNT_W  number of races resolving to 1.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values, applied synchronously at any state, mid-race included:
  - state IDLE, launch 0, chal_out 0.
  - resp_valid 0, resp_out 0, resp_ones 0.
  - internal counters 0, synchroniser flops 0.
- Reset aborts any evaluation in progress; no partial response is emitted.
- arb_in passes through a 2-flop synchroniser; only the synchronised value (arb_s) is used.
- States: IDLE, RACE, RELAX, DONE.
- IDLE:
  - chal_ready=1.
  - On chal_valid && chal_ready, chal_out <= chal_in, eval count and ones count cleared, phase timer cleared, state -> RACE.
- RACE:
  - launch=1 for exactly SETTLE_CYC cycles.
  - On the last RACE cycle, ones += arb_s.
  - State -> RELAX.
- RELAX:
  - launch=0 for exactly SETTLE_CYC cycles, letting the chain return low.
  - On the last cycle, eval count increments.
  - If eval count reaches NEVAL, go to DONE; otherwise go to RACE.
- DONE:
  - resp_valid=1.
  - resp_ones = final ones count.
  - resp_out = (ones > NEVAL/2), using integer division.
  - Outputs hold stable until resp_valid && resp_ready; state -> IDLE on the following edge.
- Latency: resp_valid rises exactly 2*SETTLE_CYC*NEVAL + 1 cycles after the accepting edge.
- chal_out stays constant from acceptance through the DONE handshake. It retains its last value in IDLE.
- chal_valid outside IDLE is ignored (chal_ready=0); no buffering.
- Handshake boundaries:
  - A resp handshake and a new chal_valid in the same cycle: the challenge is not accepted that cycle. It is accepted on the first IDLE cycle after.
  - resp_ready held high before DONE: resp_valid is still asserted for at least one cycle.
- Arithmetic: the ones counter never exceeds NEVAL, so CNT_W has no overflow.
- Illegal parameters (NEVAL even or 0, SETTLE_CYC < 4) cause an elaboration-time error.

Decomposition:
- Shared package apuf_pkg:
  - state enum (IDLE, RACE, RELAX, DONE)
  - clog2 helper used for CNT_W
  - phase-timer width constant
- One sub-module: apuf_sync2, the 2-flop synchroniser for arb_in, reusable for other PUF taps.
- FSM, phase timer, eval/ones counters and majority compare live in the top.

Test Plan:
- Timing: NEVAL=5, SETTLE_CYC=4, arb_in tied 1, challenge 0xA5A5... accepted → launch shows 5 high pulses of 4 cycles separated by 4 low cycles. resp_valid rises exactly 41 cycles after acceptance; resp_out=1, resp_ones=5.
- Majority: arb_in driven 1 during races 1, 3, 4 and 0 during races 2, 5 (NEVAL=5) → resp_out=1, resp_ones=3. With 1 only during races 2 and 5 → resp_out=0, resp_ones=2.
- Back-pressure: resp_ready held 0 for 10 cycles after DONE → resp_valid, resp_out, resp_ones and chal_out stable all 10 cycles. chal_valid held high throughout sees chal_ready=0 and is accepted on the first IDLE cycle after the handshake.
- Reset mid-operation: rst pulsed for 1 cycle during the third RACE phase → next cycle launch=0, busy=0, resp_valid=0, chal_ready=1. A following challenge yields the full 41-cycle latency.
- Challenge stability: new chal_in values presented while busy → chal_out equals the originally accepted challenge until the DONE handshake completes.
- Synchroniser: arb_in toggled asynchronously within the last 2 cycles of a RACE phase → the sample reflects the value 2 cycles earlier, with no X propagating into resp_ones.
